// File: rtl/depadder.sv
// depadder: walks a padded message stream (0x80 marker, zero fill, 64-bit
// big-endian bit length in the last two words) and recovers the message size,
// flagging malformed padding.
// Optional feature: define DEPADDER_BLOCKCNT_CHECK_EN to also require the
// minimal number of blocks for the recovered length.
module depadder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] in_word,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [63:0] msg_size,
   output logic        done,
   output logic        pad_ok,
   output logic        err_marker,
   output logic        err_align,
   output logic        err_len
);

   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  offset;
   logic [63:0] byte_cnt;
   logic [31:0] pipe_new, pipe_old;
   logic        trk_vld;
   logic [63:0] trk_idx;
   logic [7:0]  trk_val;
   logic [63:0] length;
   logic [63:0] len_l;
   logic        accept;
   logic        leave_nz;
   logic [1:0]  leave_k;
   logic [7:0]  leave_val;
   logic        chk_len, chk_marker;

   assign accept = (state == RUN) && in_valid && !start;
   assign len_l  = length >> 3;

   // Next-state logic; start restarts the stream from any state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         RUN:     if (accept && in_last) state_nxt = CHECK;
         CHECK:   state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (start) state_nxt = RUN;
   end

   // State register; in_ready tracks the RUN state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == RUN);
      end
   end

   // Latest (least-significant) nonzero byte of the word leaving the pipe
   always_comb begin
      leave_nz  = 1'b0;
      leave_k   = 2'd0;
      leave_val = 8'h00;
      for (int k = 0; k < 4; k++) begin
         if (pipe_old[31 - 8*k -: 8] != 8'h00) begin
            leave_nz  = 1'b1;
            leave_k   = 2'(k);
            leave_val = pipe_old[31 - 8*k -: 8];
         end
      end
   end

   assign chk_marker = !trk_vld || (trk_val != 8'h80) || (trk_idx != len_l);

`ifdef DEPADDER_BLOCKCNT_CHECK_EN
   logic [63:0] blk_cnt;

   // Count completed blocks (word offset 15 accepted)
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         blk_cnt <= 64'd0;
      else if (start)                    blk_cnt <= 64'd0;
      else if (accept && offset == 4'd15) blk_cnt <= blk_cnt + 64'd1;
   end

   assign chk_len = (length[2:0] != 3'd0) ||
                    (blk_cnt != ((len_l + 64'd8) >> 6) + 64'd1);
`else
   assign chk_len = (length[2:0] != 3'd0);
`endif

   // Stream datapath: counters, 2-deep pipe, nonzero tracker and results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         offset     <= 4'd0;
         byte_cnt   <= 64'd0;
         pipe_new   <= 32'd0;
         pipe_old   <= 32'd0;
         trk_vld    <= 1'b0;
         trk_idx    <= 64'd0;
         trk_val    <= 8'h00;
         length     <= 64'd0;
         msg_size   <= 64'd0;
         done       <= 1'b0;
         pad_ok     <= 1'b0;
         err_marker <= 1'b0;
         err_align  <= 1'b0;
         err_len    <= 1'b0;
      end else if (start) begin
         offset     <= 4'd0;
         byte_cnt   <= 64'd0;
         pipe_new   <= 32'd0;
         pipe_old   <= 32'd0;
         trk_vld    <= 1'b0;
         trk_idx    <= 64'd0;
         trk_val    <= 8'h00;
         length     <= 64'd0;
         msg_size   <= 64'd0;
         done       <= 1'b0;
         pad_ok     <= 1'b0;
         err_marker <= 1'b0;
         err_align  <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         if (accept) begin
            offset   <= offset + 4'd1;
            byte_cnt <= byte_cnt + 64'd4;
            pipe_old <= pipe_new;
            pipe_new <= in_word;
            // pipe_old sits 8 bytes behind the accept count
            if (leave_nz) begin
               trk_vld <= 1'b1;
               trk_idx <= byte_cnt - 64'd8 + 64'(leave_k);
               trk_val <= leave_val;
            end
            if (in_last) begin
               length    <= {pipe_new, in_word};
               err_align <= (offset != 4'd15);
            end
         end
         if (state == CHECK) begin
            done       <= 1'b1;
            msg_size   <= len_l;
            err_len    <= chk_len;
            err_marker <= chk_marker;
            pad_ok     <= !(chk_len || chk_marker || err_align);
         end
      end
   end

endmodule

// File: doc/depadder.md
DEPADDER -- requirements
Module: depadder

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle pulse that clears all results and begins a new padded stream.
REQ-004 SHALL have port in_word, input, 32: padded-stream word, big-endian bytes (bits 31:24 first in stream).
REQ-005 SHALL have port in_valid, input, 1: in_word present.
REQ-006 SHALL have port in_last, input, 1: qualifies the final word (word 15) of the final block.
REQ-007 SHALL have port in_ready, output, 1: word accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 SHALL have port msg_size, output, 64: recovered message length in bytes.
REQ-009 SHALL have port done, output, 1: results valid.
REQ-010 SHALL have port pad_ok, output, 1: padding well formed.
REQ-011 SHALL have port err_marker, output, 1: 0x80 marker missing or misplaced, or nonzero pad byte.
REQ-012 SHALL have port err_align, output, 1: in_last seen at a word offset other than 15.
REQ-013 SHALL have port err_len, output, 1: length field inconsistent.

Function
REQ-014 SHALL implement states IDLE, RUN, CHECK and DONE; start moves any non-reset state to RUN and clears all counters, trackers, results and the pipe.
REQ-015 SHALL drive in_ready high only in RUN.
REQ-016 SHALL keep a 4-bit word offset that wraps at 15, a 64-bit stream byte counter that advances by 4 per accepted word, and a block counter.
REQ-017 SHALL hold accepted words in a 2-deep pipe; only a word leaving the pipe updates the nonzero tracker, so the final 8 bytes (the length field) are never tracked.
REQ-018 SHALL make the tracker record the stream byte index and value of the latest nonzero byte, where the latest byte is the least-significant nonzero byte of the leaving word.
REQ-019 SHALL, when in_last is accepted, capture the 64-bit length as {pipe newest word, in_word} and enter CHECK; err_align SHALL set if the offset is not 15.
REQ-020 SHALL, in CHECK, take L = length >> 3 and set err_len if length[2:0] != 0.
REQ-021 SHALL, in CHECK, set err_marker if no nonzero byte was tracked, if the tracked value != 0x80, or if the tracked index != L.
REQ-022 SHALL set pad_ok = no error bit set, msg_size = L, and done = 1 on the edge that leaves CHECK, i.e. the second rising edge after the in_last accept edge.
REQ-023 SHALL hold DONE and all results until start or reset; in_valid is ignored in IDLE, CHECK and DONE.
REQ-024 SHALL, on start during RUN, abandon the stream with no result and restart.
REQ-025 SHALL size all index arithmetic at 64 bits and discard wrap-around.

Reset
REQ-026 SHALL, on reset asserted, immediately force IDLE, in_ready=0, done=0, pad_ok=0, all err_*=0, msg_size=0, and clear counters, pipe and tracker, including mid-stream.

Configuration
REQ-027 SHALL, with DEPADDER_BLOCKCNT_CHECK_EN defined, additionally set err_len in CHECK when block count != floor((L+8)/64)+1, i.e. non-minimal or truncated padding.
REQ-028 SHALL, without DEPADDER_BLOCKCNT_CHECK_EN, omit the block-count comparison and its logic; all other checks are unchanged.

Verification
REQ-029 SHALL cover: "abc" block (0x61626380, 13x 0, 0x00000000, 0x00000018 with in_last) -> done, pad_ok=1, msg_size=3.
REQ-030 SHALL cover: L=56 two-block stream (0x80000000 at word 14 of block 0, length 0x000001C0) -> pad_ok=1, msg_size=56.
REQ-031 SHALL cover: "abc" with word0=0x61626300 -> err_marker=1, pad_ok=0; and with word0=0x61626380 plus word5=0x00000001 -> err_marker=1.
REQ-032 SHALL cover: in_last asserted on word 7 -> err_align=1, done two edges later; and length 0x00000019 -> err_len=1.
REQ-033 SHALL cover: "abc" marker then an extra all-zero block ending in 0x18 -> err_len=1 with DEPADDER_BLOCKCNT_CHECK_EN defined, pad_ok=1 without it.
REQ-034 SHALL cover: reset pulsed after word 9 -> all outputs 0 at once; a new start followed by the "abc" stream -> pad_ok=1.
